// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg
//   MEM->WB pipeline register with a valid/ready handshake. With SKID_EN=1 it
//   holds up to two entries (head + skid), so in_ready depends only on
//   registered state and WB stalls never reach MEM combinationally. With
//   SKID_EN=0 it is a single register, and in_ready passes out_ready through.
//   A forwarding tap exposes the head's write-back value to the EX stage.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   flush               synchronous; empties the block and drops same-cycle input
//   in_valid/in_ready   MEM-side handshake
//   in_mem_read, in_wb_en, in_dest, in_mem_data, in_alu_result   entry fields
//   out_valid/out_ready WB-side handshake
//   out_mem_read, out_wb_en, out_dest, out_mem_data, out_alu_result  head fields
//   out_wb_value        load ? memory data : ALU result
//   fwd_valid, fwd_dest, fwd_value   forwarding tap for the EX stage
//   occupancy           number of buffered entries (0..2)
module mem_wb_elastic_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_wb_en,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_read,
  output logic              out_wb_en,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_wb_value,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value,
  output logic [1:0]        occupancy
);

  // The state value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int ENT_W = 2 + REG_AW + 2 * DATA_W;

  state_t             state_p0;
  state_t             state_nx;
  logic [ENT_W-1:0]   in_ent;
  logic [ENT_W-1:0]   head_p0;
  logic [ENT_W-1:0]   skid_p0;
  logic               head_wb_en;
  logic               accept;
  logic               load_in;
  logic               load_skid;
  logic               load_from_skid;

  assign in_ent = {in_mem_read, in_wb_en, in_dest, in_mem_data, in_alu_result};

  // With the skid buffer, readiness comes from registered state only.
  assign in_ready = SKID_EN ? (state_p0 != FULL)
                            : ((state_p0 == EMPTY) | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nx       = state_p0;
    load_in        = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    if (flush) begin
      // Flush wins over both accept and consume; any same-cycle input is lost.
      state_nx = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (accept) begin
            load_in  = 1'b1;
            state_nx = ONE;
          end
        end
        ONE: begin
          // Without a skid, accept in ONE implies out_ready (in_ready gating).
          if (accept && (out_ready || !SKID_EN)) begin
            load_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nx  = FULL;
          end else if (out_ready) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            load_from_skid = 1'b1;
            state_nx       = ONE;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Stage p0: state and entry storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (load_in) begin
        head_p0 <= in_ent;
      end else if (load_from_skid) begin
        head_p0 <= skid_p0;
      end
      if (load_skid) begin
        skid_p0 <= in_ent;
      end
    end
  end

  // Outputs are driven straight from the head register; the write-back mux
  // adds no latency.
  assign {out_mem_read, head_wb_en, out_dest, out_mem_data, out_alu_result} = head_p0;

  assign out_valid    = (state_p0 != EMPTY);
  assign out_wb_en    = head_wb_en & out_valid;
  assign out_wb_value = out_mem_read ? out_mem_data : out_alu_result;
  assign fwd_valid    = out_wb_en;
  assign fwd_dest     = out_dest;
  assign fwd_value    = out_wb_value;
  assign occupancy    = state_p0;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
module tb_mem_wb_elastic_reg;

  typedef struct packed {
    logic        mr;
    logic        we;
    logic [3:0]  dest;
    logic [31:0] md;
    logic [31:0] alu;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        in_wb_en = 1'b0;
  logic [3:0]  in_dest = '0;
  logic [31:0] in_mem_data = '0;
  logic [31:0] in_alu_result = '0;
  logic        out_ready = 1'b0;

  logic        ir1, ov1, omr1, owe1, fv1;
  logic [3:0]  od1, fd1;
  logic [31:0] omd1, oalu1, owb1, fval1;
  logic [1:0]  occ1;
  logic        ir0, ov0, omr0, owe0, fv0;
  logic [3:0]  od0, fd0;
  logic [31:0] omd0, oalu0, owb0, fval0;
  logic [1:0]  occ0;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t q1[$];
  entry_t q0[$];
  logic   rdy1 = 1'b1;
  logic   rdy0 = 1'b1;

  always #5 clk = ~clk;

  mem_wb_elastic_reg #(.DATA_W(32), .REG_AW(4), .SKID_EN(1'b1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1),
    .in_mem_read(in_mem_read), .in_wb_en(in_wb_en), .in_dest(in_dest),
    .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
    .out_valid(ov1), .out_ready(out_ready),
    .out_mem_read(omr1), .out_wb_en(owe1), .out_dest(od1),
    .out_mem_data(omd1), .out_alu_result(oalu1), .out_wb_value(owb1),
    .fwd_valid(fv1), .fwd_dest(fd1), .fwd_value(fval1), .occupancy(occ1)
  );

  mem_wb_elastic_reg #(.DATA_W(32), .REG_AW(4), .SKID_EN(1'b0)) u_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0),
    .in_mem_read(in_mem_read), .in_wb_en(in_wb_en), .in_dest(in_dest),
    .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
    .out_valid(ov0), .out_ready(out_ready),
    .out_mem_read(omr0), .out_wb_en(owe0), .out_dest(od0),
    .out_mem_data(omd0), .out_alu_result(oalu0), .out_wb_value(owb0),
    .fwd_valid(fv0), .fwd_dest(fd0), .fwd_value(fval0), .occupancy(occ0)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one DUT against its model: queue size, expected ready, expected head.
  task automatic chk(input string tag, input int sz, input entry_t h, input logic rdy,
                     input logic ov, input logic ir, input logic omr, input logic owe,
                     input logic [3:0] od, input logic [31:0] omd, input logic [31:0] oalu,
                     input logic [31:0] owb, input logic fv, input logic [3:0] fd,
                     input logic [31:0] fval, input logic [1:0] occ);
    logic [31:0] wb;
    cmp({tag, "_out_valid"}, 64'(ov), 64'(sz > 0));
    cmp({tag, "_occupancy"}, 64'(occ), 64'(sz));
    cmp({tag, "_in_ready"}, 64'(ir), 64'(rdy));
    if (sz > 0) begin
      wb = h.mr ? h.md : h.alu;
      cmp({tag, "_dest"}, 64'(od), 64'(h.dest));
      cmp({tag, "_mem_read"}, 64'(omr), 64'(h.mr));
      cmp({tag, "_wb_en"}, 64'(owe), 64'(h.we));
      cmp({tag, "_mem_data"}, 64'(omd), 64'(h.md));
      cmp({tag, "_alu"}, 64'(oalu), 64'(h.alu));
      cmp({tag, "_wb_value"}, 64'(owb), 64'(wb));
      cmp({tag, "_fwd_valid"}, 64'(fv), 64'(h.we));
      cmp({tag, "_fwd_dest"}, 64'(fd), 64'(h.dest));
      cmp({tag, "_fwd_value"}, 64'(fval), 64'(wb));
    end else begin
      cmp({tag, "_wb_en_idle"}, 64'(owe), 64'd0);
      cmp({tag, "_fwd_valid_idle"}, 64'(fv), 64'd0);
    end
  endtask

  // Monitor: checks both DUTs mid-cycle and retires the head on a transfer.
  always @(negedge clk) begin
    if (!reset) begin
      chk("skid", q1.size(), (q1.size() > 0) ? q1[0] : '0, rdy1,
          ov1, ir1, omr1, owe1, od1, omd1, oalu1, owb1, fv1, fd1, fval1, occ1);
      chk("single", q0.size(), (q0.size() > 0) ? q0[0] : '0, rdy0,
          ov0, ir0, omr0, owe0, od0, omd0, oalu0, owb0, fv0, fd0, fval0, occ0);
      if (!flush && out_ready) begin
        if (q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) void'(q0.pop_front());
      end
    end
  end

  // Advance one clock: apply the model's view of the edge, then drive new inputs.
  task automatic step(input logic v, input logic mr, input logic we, input logic [3:0] d,
                      input logic [31:0] md, input logic [31:0] alu,
                      input logic ordy, input logic fl);
    entry_t e;
    @(posedge clk);
    e = '{mr: in_mem_read, we: in_wb_en, dest: in_dest, md: in_mem_data, alu: in_alu_result};
    if (flush) begin
      q1.delete();
      q0.delete();
    end else if (in_valid) begin
      if (rdy1) q1.push_back(e);
      if (rdy0) q0.push_back(e);
    end
    #1;
    in_valid = v; in_mem_read = mr; in_wb_en = we; in_dest = d;
    in_mem_data = md; in_alu_result = alu; out_ready = ordy; flush = fl;
    rdy1 = (q1.size() < 2);
    rdy0 = (q0.size() == 0) || ordy;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    // Reset state, sampled while reset is still asserted and after release.
    cmp("rst_out_valid", 64'(ov1), 64'd0);
    cmp("rst_in_ready", 64'(ir1), 64'd1);
    cmp("rst_wb_value", 64'(owb1), 64'd0);
    reset = 1'b0;
    #1;
    cmp("rst_dest", 64'(od1), 64'd0);
    cmp("rst_occupancy", 64'(occ1), 64'd0);
    cmp("rst_fwd_valid", 64'(fv1), 64'd0);

    // Simple ALU write-back, then a load selecting memory data.
    step(1'b1, 1'b0, 1'b1, 4'h3, 32'h0, 32'h10, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'h5, 32'hDEADBEEF, 32'h40, 1'b1, 1'b0);
    idle(1'b0);
    cmp("load_wb_value", 64'(owb1), 64'hDEADBEEF);
    cmp("load_fwd_value", 64'(fval1), 64'hDEADBEEF);
    idle(1'b1);
    idle(1'b1);

    // Stall with A, B, C offered; then release and drain in order.
    step(1'b1, 1'b0, 1'b1, 4'h1, 32'h0, 32'h1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h2, 32'h0, 32'h2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h3, 32'h0, 32'h3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h3, 32'h0, 32'h3, 1'b0, 1'b0);
    cmp("stall_in_ready", 64'(ir1), 64'd0);
    cmp("stall_head_alu", 64'(oalu1), 64'h1);
    step(1'b1, 1'b0, 1'b1, 4'h3, 32'h0, 32'h3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h3, 32'h0, 32'h3, 1'b1, 1'b0);
    repeat (4) idle(1'b1);

    // Fill to two entries, then flush with D offered in the same cycle.
    step(1'b1, 1'b0, 1'b1, 4'h7, 32'h0, 32'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h8, 32'h0, 32'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h9, 32'h0, 32'h4, 1'b1, 1'b1);
    idle(1'b0);
    cmp("flush_occupancy", 64'(occ1), 64'd0);
    cmp("flush_in_ready", 64'(ir1), 64'd1);
    idle(1'b1);

    // Asynchronous reset between edges with one entry held.
    step(1'b1, 1'b1, 1'b1, 4'hA, 32'h55AA55AA, 32'h99, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    q1.delete();
    q0.delete();
    rdy1 = 1'b1;
    rdy0 = 1'b1;
    #1;
    cmp("async_rst_out_valid", 64'(ov1), 64'd0);
    cmp("async_rst_occupancy", 64'(occ1), 64'd0);
    cmp("async_rst_wb_value", 64'(owb1), 64'd0);
    cmp("async_rst_single_valid", 64'(ov0), 64'd0);
    #1;
    reset = 1'b0;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 4'($urandom),
           $urandom, $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0));
    end
    repeat (4) idle(1'b1);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
